fm_add_p2s_x: RTL and testbench

//  Parallel-to-serial splitter: accepts one wide frame of SEQ_CNT words and emits it as
//  SEQ_CNT consecutive APP_DATA_WIDTH words over a valid/ready stream, word 0 first.

---
 rtl/fm_add_p2s_x_if.sv | 24 ++
 rtl/fm_add_p2s_x.sv | 122 ++++++++++++
 tb/tb_fm_add_p2s_x.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fm_add_p2s_x_if.sv
// Stream bundle for the fm_add parallel-to-serial splitter: wide frame in, word stream out.
interface fm_add_p2s_x_if #(
  parameter int SEQ_CNT        = 5,
  parameter int APP_DATA_WIDTH = 64
);
  logic [APP_DATA_WIDTH*SEQ_CNT-1:0] par;
  logic                              par_valid;
  logic                              par_ready;
  logic [APP_DATA_WIDTH-1:0]         seq;
  logic                              seq_valid;
  logic                              seq_ready;
  logic                              seq_last;
  logic                              busy;

  modport master (
    output par, par_valid, seq_ready,
    input  par_ready, seq, seq_valid, seq_last, busy
  );

  modport slave (
    input  par, par_valid, seq_ready,
    output par_ready, seq, seq_valid, seq_last, busy
  );
endinterface

// File: rtl/fm_add_p2s_x.sv
// Splits one SEQ_CNT-word frame into consecutive APP_DATA_WIDTH words, word 0 first.
// Define FM_P2S_PREFETCH_EN to add a one-frame input buffer (par_ready loses its seq_ready path).
module fm_add_p2s_x #(
  parameter int SEQ_CNT        = 5,
  parameter int APP_DATA_WIDTH = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  fm_add_p2s_x_if.slave  bus
);
  localparam int         PW       = APP_DATA_WIDTH * SEQ_CNT;
  localparam logic [5:0] LAST_IDX = 6'(SEQ_CNT - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t          state_r, state_s;
  logic [5:0]      cnt_r, cnt_s;
  logic [PW-1:0]   shift_r, shift_s;
  logic            buf_full_r, buf_full_s;
  logic            seq_last_s, out_xfer_s, in_xfer_s, par_ready_s;
`ifdef FM_P2S_PREFETCH_EN
  logic [PW-1:0]   buf_r, buf_s;
`endif

  assign seq_last_s = (state_r == SEND) && (cnt_r == LAST_IDX);
  assign out_xfer_s = (state_r == SEND) && bus.seq_ready;
  assign in_xfer_s  = bus.par_valid && par_ready_s;

  // Input handshake: zero-bubble handoff without buffer, registered gating with buffer
  always_comb begin
    par_ready_s = 1'b0;
`ifdef FM_P2S_PREFETCH_EN
    par_ready_s = rst_n && !buf_full_r;
`else
    par_ready_s = rst_n && ((state_r == IDLE) || (seq_last_s && bus.seq_ready));
`endif
  end

  // Next-state logic for FSM, word counter, shift register and prefetch buffer
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    shift_s    = shift_r;
    buf_full_s = buf_full_r;
`ifdef FM_P2S_PREFETCH_EN
    buf_s      = buf_r;
`endif
    case (state_r)
      IDLE: begin
        if (in_xfer_s) begin
          shift_s = bus.par;
          cnt_s   = 6'd0;
          state_s = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (out_xfer_s && seq_last_s) begin
          cnt_s = 6'd0;
          // A buffered frame always precedes one offered on the same edge
          if (buf_full_r) begin
`ifdef FM_P2S_PREFETCH_EN
            shift_s = buf_r;
`endif
            buf_full_s = 1'b0;
          end else if (in_xfer_s) begin
            shift_s = bus.par;
          end else begin
            state_s = IDLE;
          end
        end else begin
          if (out_xfer_s) begin
            shift_s = shift_r >> APP_DATA_WIDTH;
            cnt_s   = cnt_r + 6'd1;
          end else begin
            shift_s = shift_r;
          end
          if (in_xfer_s) begin
`ifdef FM_P2S_PREFETCH_EN
            buf_s = bus.par;
`endif
            buf_full_s = 1'b1;
          end else begin
            buf_full_s = buf_full_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 6'd0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 6'd0;
      shift_r    <= '0;
      buf_full_r <= 1'b0;
`ifdef FM_P2S_PREFETCH_EN
      buf_r      <= '0;
`endif
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      shift_r    <= shift_s;
      buf_full_r <= buf_full_s;
`ifdef FM_P2S_PREFETCH_EN
      buf_r      <= buf_s;
`endif
    end
  end

  assign bus.par_ready = par_ready_s;
  assign bus.seq       = shift_r[APP_DATA_WIDTH-1:0];
  assign bus.seq_valid = (state_r == SEND);
  assign bus.seq_last  = seq_last_s;
  assign bus.busy      = (state_r == SEND) || buf_full_r;
endmodule

// File: tb/tb_fm_add_p2s_x.sv
// Scoreboard bench for fm_add_p2s_x: a 5x64 instance for the main tests and a 1x8 instance.
module tb_fm_add_p2s_x;
  localparam int N0 = 5;
  localparam int W0 = 64;
  localparam int N1 = 1;
  localparam int W1 = 8;
`ifdef FM_P2S_PREFETCH_EN
  localparam int PF = 1;
`else
  localparam int PF = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc0 = 0;
  int   acc1 = 0;
  int   acc_cyc0 = 0;
  int   acc_cyc1 = 0;
  logic sv0, sv1;
  logic [W0-1:0] sq0;

  logic [W0:0] q0[$];
  logic [W1:0] q1[$];

  always #5 clk = ~clk;

  fm_add_p2s_x_if #(.SEQ_CNT(N0), .APP_DATA_WIDTH(W0)) b0 ();
  fm_add_p2s_x_if #(.SEQ_CNT(N1), .APP_DATA_WIDTH(W1)) b1 ();

  fm_add_p2s_x #(.SEQ_CNT(N0), .APP_DATA_WIDTH(W0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  fm_add_p2s_x #(.SEQ_CNT(N1), .APP_DATA_WIDTH(W1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N0*W0-1:0] rnd_frame0();
    logic [N0*W0-1:0] r;
    for (int i = 0; i < N0 * W0 / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: an accepted frame becomes its words in index order, last flag on the final one
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && b0.par_valid === 1'b1 && b0.par_ready === 1'b1) begin
      for (int i = 0; i < N0; i++) q0.push_back({(i == N0 - 1), b0.par[W0*i +: W0]});
      acc0++;
    end
    if (rst_n === 1'b1 && b1.par_valid === 1'b1 && b1.par_ready === 1'b1) begin
      for (int i = 0; i < N1; i++) q1.push_back({(i == N1 - 1), b1.par[W1*i +: W1]});
      acc1++;
    end
  end

  // Output monitor for the 5x64 instance
  initial begin
    logic          st;
    logic [W0-1:0] pv;
    logic [W0:0]   e;
    st = 1'b0;
    pv = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (st) begin
          chk("stall_valid0", b0.seq_valid, 1'b1);
          chk("stall_data0", b0.seq, pv);
        end
        if (b0.seq_valid === 1'b1 && b0.seq_ready === 1'b1) begin
          if (q0.size() == 0) begin
            chk("unexpected_word0", b0.seq_valid, 1'b0);
          end else begin
            e = q0.pop_front();
            chk("seq_data0", b0.seq, e[W0-1:0]);
            chk("seq_last0", b0.seq_last, e[W0]);
          end
        end
        st = (b0.seq_valid === 1'b1) && (b0.seq_ready === 1'b0);
        pv = b0.seq;
      end else begin
        st = 1'b0;
      end
    end
  end

  // Output monitor for the 1x8 instance
  initial begin
    logic [W1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && b1.seq_valid === 1'b1 && b1.seq_ready === 1'b1) begin
        if (q1.size() == 0) begin
          chk("unexpected_word1", b1.seq_valid, 1'b0);
        end else begin
          e = q1.pop_front();
          chk("seq_data1", b1.seq, e[W1-1:0]);
          chk("seq_last1", b1.seq_last, e[W1]);
        end
      end
    end
  end

  // One clock: observe at the falling edge, drop par_valid after an accept, return 1 after the rise
  task automatic tick();
    logic a0, a1;
    @(negedge clk);
    a0  = (rst_n === 1'b1) && (b0.par_valid === 1'b1) && (b0.par_ready === 1'b1);
    a1  = (rst_n === 1'b1) && (b1.par_valid === 1'b1) && (b1.par_ready === 1'b1);
    sv0 = b0.seq_valid;
    sq0 = b0.seq;
    sv1 = b1.seq_valid;
    @(posedge clk);
    #1;
    if (a0) begin
      b0.par_valid = 1'b0;
      acc_cyc0 = cyc;
    end
    if (a1) begin
      b1.par_valid = 1'b0;
      acc_cyc1 = cyc;
    end
  endtask

  task automatic send0(input logic [N0*W0-1:0] f, output int acc);
    b0.par = f;
    b0.par_valid = 1'b1;
    for (int k = 0; k < 100 && b0.par_valid; k++) tick();
    if (b0.par_valid) chk("send_timeout0", b0.par_valid, 1'b0);
    acc = acc_cyc0;
  endtask

  task automatic send1(input logic [W1-1:0] f, output int acc);
    b1.par = f;
    b1.par_valid = 1'b1;
    for (int k = 0; k < 100 && b1.par_valid; k++) tick();
    if (b1.par_valid) chk("send_timeout1", b1.par_valid, 1'b0);
    acc = acc_cyc1;
  endtask

  task automatic drain();
    b0.seq_ready = 1'b1;
    b1.seq_ready = 1'b1;
    for (int k = 0; k < 200 && (q0.size() != 0 || q1.size() != 0 ||
         b0.seq_valid === 1'b1 || b1.seq_valid === 1'b1); k++) tick();
    @(negedge clk);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    chk("drain_busy0", b0.busy, 1'b0);
    chk("drain_busy1", b1.busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  localparam logic [N0*W0-1:0] F_INC = {64'h55, 64'h44, 64'h33, 64'h22, 64'h11};

  initial begin
    int a, b, na;
    rst_n = 1'b0;
    b0.par = F_INC;
    b0.par_valid = 1'b1;
    b0.seq_ready = 1'b1;
    b1.par = '0;
    b1.par_valid = 1'b0;
    b1.seq_ready = 1'b1;

    // Reset held with par_valid asserted
    repeat (3) begin
      @(negedge clk);
      chk("rst_par_ready", b0.par_ready, 1'b0);
      chk("rst_seq_valid", b0.seq_valid, 1'b0);
      chk("rst_busy", b0.busy, 1'b0);
    end
    chk("rst_seq", b0.seq, 64'h0);
    chk("rst_seq_last", b0.seq_last, 1'b0);
    @(posedge clk);
    #1;
    b0.par_valid = 1'b0;
    rst_n = 1'b1;

    // Single frame, words visible in cycles t+1..t+5, then idle
    send0(F_INC, a);
    for (int i = 0; i < N0; i++) begin
      @(negedge clk);
      chk("t2_valid", b0.seq_valid, 1'b1);
    end
    @(negedge clk);
    chk("t2_idle_valid", b0.seq_valid, 1'b0);
    chk("t2_idle_busy", b0.busy, 1'b0);
    @(posedge clk);
    #1;

    // Back-to-back frames with par_valid held
    send0(rnd_frame0(), a);
    b0.par = rnd_frame0();
    b0.par_valid = 1'b1;
    for (int k = 0; k < 2 * N0; k++) begin
      tick();
      chk("t3_no_gap", sv0, 1'b1);
    end
    chk("t3_second_accepted", b0.par_valid, 1'b0);
    chk("t3_accept_edge", acc_cyc0 - a, (PF == 1) ? 1 : N0);
    drain();

    // Backpressure at word 2 while a further frame is offered
    send0(F_INC, a);
    tick();
    tick();
    b0.seq_ready = 1'b0;
    b0.par = rnd_frame0();
    b0.par_valid = 1'b1;
    na = acc0;
    repeat (4) begin
      tick();
      chk("t4_hold_data", sq0, 64'h33);
      chk("t4_hold_valid", sv0, 1'b1);
    end
    chk("t4_accepts", acc0 - na, PF);
    b0.seq_ready = 1'b1;
    for (int k = 0; k < 50 && b0.par_valid; k++) tick();
    drain();

    // Reset after word 1 has transferred; remaining words must vanish
    send0(F_INC, a);
    tick();
    tick();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_no_leftover", b0.seq_valid, 1'b0);
    chk("t5_busy", b0.busy, 1'b0);
    @(posedge clk);
    #1;
    send0(rnd_frame0(), a);
    drain();

    // Single-word frames: one word per cycle, last on every word
    send1(8'hA5, a);
    b1.par = 8'h5A;
    b1.par_valid = 1'b1;
    tick();
    chk("t6_valid_a5", sv1, 1'b1);
    b = acc_cyc1;
    tick();
    chk("t6_valid_5a", sv1, 1'b1);
    chk("t6_rate", b - a, 1);
    drain();

    // Randomised traffic on both instances
    for (int k = 0; k < 400; k++) begin
      b0.seq_ready = ($urandom % 4) != 0;
      b1.seq_ready = ($urandom % 3) != 0;
      if (!b0.par_valid && ($urandom % 2) == 1) begin
        b0.par = rnd_frame0();
        b0.par_valid = 1'b1;
      end
      if (!b1.par_valid && ($urandom % 2) == 1) begin
        b1.par = 8'($urandom);
        b1.par_valid = 1'b1;
      end
      tick();
    end
    b0.par_valid = 1'b0;
    b1.par_valid = 1'b0;
    drain();
    chk("accepts_seen0", (acc0 > 20), 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
